// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus drain controller feeding a UART transmitter over WE/READY.
// Optional macro UART_TXFIFO_CRLF_EN inserts a CR (0x0D) ahead of every LF (0x0A) sent.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [7:0]          IN_DATA,
  input  logic                IN_WE,
  output logic                FULL,
  output logic                EMPTY,
  output logic [DEPTH_LOG2:0] COUNT,
  output logic                OVF,
  input  logic                OVF_CLR,
  output logic [7:0]          TX_DATA,
  output logic                TX_WE,
  input  logic                TX_READY
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StSent, StBusy, StDrain} state_e;

  state_e                state_q, state_d;
  logic                  busy_cnt_q, busy_cnt_d;

  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  ovf_q;
  logic                  tx_we_q;
  logic [7:0]            tx_data_q;

  logic                  do_wr, do_rd, issue;
  logic [7:0]            head, issue_data;

  // count never exceeds depth, so its MSB alone marks full
  assign FULL    = count_q[DEPTH_LOG2];
  assign EMPTY   = (count_q == '0);
  assign COUNT   = count_q;
  assign OVF     = ovf_q;
  assign TX_WE   = tx_we_q;
  assign TX_DATA = tx_data_q;

  assign head  = mem_q[rd_ptr_q];
  assign do_wr = IN_WE && !FULL;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      busy_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    busy_cnt_d = 1'b0;
    unique case (state_q)
      StIdle:  if (!EMPTY && TX_READY) state_d = StSent;
      // READY is ignored in StSent: the transmitter drops it on the edge that samples WE
      StSent:  state_d = StBusy;
      // Fall through to StDrain after two cycles even if READY never dropped
      StBusy: begin
        if (!TX_READY || busy_cnt_q) state_d = StDrain;
        else                         busy_cnt_d = 1'b1;
      end
      StDrain: if (TX_READY) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef UART_TXFIFO_CRLF_EN
  logic cr_done_q;
  logic insert_cr;

  // Output / issue decode
  always_comb begin
    issue      = (state_q == StIdle) && !EMPTY && TX_READY;
    insert_cr  = issue && (head == 8'h0A) && !cr_done_q;
    do_rd      = issue && !insert_cr;
    issue_data = insert_cr ? 8'h0D : head;
  end

  // cr_done marks that the CR ahead of the current head LF has already gone out
  always_ff @(posedge CLK) begin
    if (RST)        cr_done_q <= 1'b0;
    else if (issue) cr_done_q <= insert_cr;
  end
`else
  // Output / issue decode
  always_comb begin
    issue      = (state_q == StIdle) && !EMPTY && TX_READY;
    do_rd      = issue;
    issue_data = head;
  end
`endif

  always_ff @(posedge CLK) begin
    if (do_wr) mem_q[wr_ptr_q] <= IN_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      tx_we_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (DEPTH_LOG2)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (DEPTH_LOG2)'(1);
      if (do_wr && !do_rd)      count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
      else if (!do_wr && do_rd) count_q <= count_q - (DEPTH_LOG2 + 1)'(1);

      // A dropped write takes priority over a same-cycle clear
      if (IN_WE && FULL) ovf_q <= 1'b1;
      else if (OVF_CLR)  ovf_q <= 1'b0;

      tx_we_q <= issue;
      if (issue) tx_data_q <= issue_data;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO plus drain controller sitting directly upstream of the UART transmitter (UartTx).
- Accepts console bytes from the CPU/MMIO side at up to one byte per cycle.
- Feeds them to the transmitter one at a time using its WE/READY handshake.
- Decouples CPU writes from the 10-bit-time serial frame so software does not stall per character.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth in bytes; depth = 2**DEPTH_LOG2, range 1..10.

Ports:
- CLK  input  1  system clock; one clock.
- RST  input  1  reset, synchronous and active-high.
- IN_DATA  input  8  byte to enqueue.
- IN_WE  input  1  enqueue strobe, one byte per asserted cycle.
- FULL  output  1  count == depth (combinational from count register).
- EMPTY  output  1  count == 0 (combinational from count register).
- COUNT  output  DEPTH_LOG2+1  bytes currently stored.
- OVF  output  1  sticky overflow flag.
- OVF_CLR  input  1  clears OVF.
- TX_DATA  output  8  byte presented to UartTx DATA.
- TX_WE  output  1  one-cycle strobe to UartTx WE.
- TX_READY  input  1  UartTx READY.

Behaviour:
- Reset (RST=1 at a CLK edge): wr_ptr=0, rd_ptr=0, count=0, state=IDLE. Outputs: TX_WE=0, TX_DATA=0, OVF=0, EMPTY=1, FULL=0, COUNT=0. Storage contents are don't-care.
- Reset mid-frame: the FIFO is emptied. The transmitter finishes its current frame on its own; after reset the FSM waits in IDLE for TX_READY=1 before issuing.
- Enqueue: IN_WE=1 and count<depth (sampled before any same-cycle dequeue) writes mem[wr_ptr]<=IN_DATA, wr_ptr wraps modulo depth, count+1.
- Overflow: IN_WE=1 while FULL drops the byte and sets OVF<=1. Storage and pointers are unchanged.
- OVF clear: OVF_CLR=1 clears OVF. If OVF_CLR and an overflowing write occur in the same cycle, set wins (OVF=1).
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance.
- Drain FSM states:
  - IDLE: if count!=0 and TX_READY=1, then TX_DATA<=mem[rd_ptr], TX_WE<=1, rd_ptr+1 (wraps), count-1, go to SENT. Otherwise TX_WE<=0.
  - SENT (1 cycle): TX_WE<=0. Go to BUSY. TX_READY is ignored here because UartTx drops READY at the same edge that samples WE.
  - BUSY: wait until TX_READY=0, then go to DRAIN. If TX_READY is still 1 after 2 cycles in BUSY, go to DRAIN anyway (guards a transmitter that never dropped READY).
  - DRAIN: wait until TX_READY=1, then go to IDLE.
- TX_WE is high exactly one cycle per byte. TX_DATA holds its value until the next issue.
- Latency: a byte written into an empty FIFO with TX_READY=1 appears on TX_WE/TX_DATA 2 edges after the IN_WE edge (edge 1 stores it, edge 2 issues it).
- Ordering is strict FIFO. There is no reordering and no duplication.
- COUNT never exceeds depth and never underflows; a dequeue occurs only when count!=0.

Optional Feature:
- Macro: UART_TXFIFO_CRLF_EN.
- Defined: a dequeued-candidate byte 0x0A is preceded by 0x0D.
  - In IDLE, when the head byte is 0x0A and internal flag cr_done=0, the FSM issues TX_DATA=0x0D without popping and sets cr_done=1.
  - The next issue pops and sends 0x0A and clears cr_done.
  - cr_done resets to 0.
  - COUNT reflects stored bytes only; the inserted CR is not counted.
- Undefined: bytes pass unmodified and cr_done does not exist.

Test Plan:
- Reset, then one write of 0x41 with TX_READY held 1 -> TX_WE pulses once 2 edges later with TX_DATA=0x41; COUNT returns to 0; EMPTY=1.
- DEPTH_LOG2=4; 16 back-to-back writes 0x00..0x0F while TX_READY=0 -> FULL=1, COUNT=16. A 17th write of 0xFF -> OVF=1 and COUNT stays 16. Raise TX_READY with real UartTx (SERIAL_WCNT=4) -> bytes 0x00..0x0F emitted in order; 0xFF never appears.
- Write and dequeue in the same cycle at COUNT=5 -> COUNT stays 5; output order preserved across pointer wrap (write 40 bytes in bursts of 10).
- OVF set, then OVF_CLR=1 pulse with no write -> OVF=0. OVF_CLR coincident with an overflowing write -> OVF=1.
- Assert RST while a byte is mid-frame in UartTx with 3 bytes queued -> COUNT=0 and TX_WE=0 next edge; no new TX_WE until TX_READY returns to 1 and a new write occurs.
- With UART_TXFIFO_CRLF_EN, write 0x61,0x0A,0x62 -> transmitter receives 0x61,0x0D,0x0A,0x62. Without the macro -> 0x61,0x0A,0x62.
